// File: rtl/bcd_ripple_sampler_if.sv
// Bus between the units-digit sampler and its consumer.
//   master : drives DIGIT_IN (raw ripple digit) and CLEAR, observes the results
//   slave  : the sampler; publishes DIGIT_OUT, UPPER_OUT, UPDATE, CARRY,
//            OVERFLOW and ERROR
interface bcd_ripple_sampler_if #(
    parameter int UPPER_DIGITS = 3
);
    logic [3:0]                DIGIT_IN;
    logic                      CLEAR;
    logic [3:0]                DIGIT_OUT;
    logic [4*UPPER_DIGITS-1:0] UPPER_OUT;
    logic                      UPDATE;
    logic                      CARRY;
    logic                      OVERFLOW;
    logic                      ERROR;

    modport master (
        output DIGIT_IN, CLEAR,
        input  DIGIT_OUT, UPPER_OUT, UPDATE, CARRY, OVERFLOW, ERROR
    );

    modport slave (
        input  DIGIT_IN, CLEAR,
        output DIGIT_OUT, UPPER_OUT, UPDATE, CARRY, OVERFLOW, ERROR
    );
endinterface

// File: rtl/bcd_ripple_sampler.sv
// Samples the glitchy, asynchronous BCD digit of a ripple counter into the CLK
// domain, accepts it only after it has held still for STABLE_CYCLES edges, and
// extends the count with UPPER_DIGITS synchronous BCD decades.
//   CLK    : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : slave modport -- DIGIT_IN/CLEAR in; DIGIT_OUT, UPPER_OUT,
//            UPDATE, CARRY, OVERFLOW, ERROR out (all registered)
module bcd_ripple_sampler #(
    parameter int STABLE_CYCLES = 3,
    parameter int UPPER_DIGITS  = 3
) (
    input  logic                 CLK,
    input  logic                 reset,
    bcd_ripple_sampler_if.slave  bus
);
    localparam int         UW     = 4 * UPPER_DIGITS;
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [3:0]    s1_q, s2_q;
    logic [3:0]    cand_q, cand_d, cnt_q, cnt_d;
    logic [3:0]    dout_q, dout_d;
    logic [UW-1:0] upper_q, upper_d, upper_inc;
    logic          upd_q, upd_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
    logic          same, accept, wrap, all9;

    // Stability filter: cand always ends up equal to s2, so accepting cand_d
    // is accepting the synchronised value.
    always_comb begin
        same   = (s2_q == cand_q);
        cand_d = s2_q;
        cnt_d  = 4'd1;
        if (same) begin
            cand_d = cand_q;
            cnt_d  = (cnt_q >= STABLE) ? STABLE : cnt_q + 4'd1;
        end
        // Only the edge on which the run length first hits STABLE accepts;
        // a saturated counter holding steady must not re-fire.
        accept = (cnt_d == STABLE) && !(same && cnt_q == STABLE) && (cand_d != dout_q);
    end

    // Ripple +1 through the upper decades in a single edge.
    always_comb begin
        logic c;
        c         = 1'b1;
        upper_inc = upper_q;
        for (int i = 0; i < UPPER_DIGITS; i++) begin
            if (c) begin
                if (upper_q[4*i +: 4] == 4'd9) begin
                    upper_inc[4*i +: 4] = 4'd0;
                end else begin
                    upper_inc[4*i +: 4] = upper_q[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        all9 = c;
    end

    always_comb begin
        dout_d  = dout_q;
        upper_d = upper_q;
        upd_d   = 1'b0;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q;
        wrap    = 1'b0;
        if (accept) begin
            if (cand_d <= 4'd9) begin
                dout_d = cand_d;
                upd_d  = 1'b1;
                wrap   = (cand_d == 4'd0) && (dout_q == 4'd9);
            end else begin
                err_d = 1'b1;
            end
        end
        // CLEAR beats a coincident wrap on the decades and flags; the units
        // digit still follows the physical counter.
        if (bus.CLEAR) begin
            upper_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else if (wrap) begin
            carry_d = 1'b1;
            upper_d = upper_inc;
            if (all9) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            upper_q <= '0;
            upd_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= bus.DIGIT_IN;
            s2_q    <= s1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            upper_q <= upper_d;
            upd_q   <= upd_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.DIGIT_OUT = dout_q;
    assign bus.UPPER_OUT = upper_q;
    assign bus.UPDATE    = upd_q;
    assign bus.CARRY     = carry_q;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.ERROR     = err_q;
endmodule
